// File: rtl/sig_gen_pkg.sv
// Shared definitions for the triangle-wave signal generator control path.
// Holds tip limits, waveform form codes, the control FSM state type and
// the tip clamp helper used when a new configuration is accepted.
package sig_gen_pkg;

    localparam logic [4:0] TIP_MIN   = 5'd1;
    localparam logic [4:0] TIP_MAX   = 5'd19;
    localparam logic [4:0] TIP_RESET = 5'd10;

    localparam logic [1:0] FORM_TRI         = 2'b00;
    localparam logic [1:0] FORM_TRI_PLATEAU = 2'b01;
    localparam logic [1:0] FORM_TRI_INV     = 2'b10;
    localparam logic [1:0] FORM_TRI_FOLD    = 2'b11;

    typedef enum logic {
        IDLE,
        PENDING
    } ctrl_state_t;

    // Tip 0 or 20+ would put the apex on a period edge and make the
    // downstream slope divide by zero; pin it to the nearest legal value.
    function automatic logic [4:0] clamp_tip(input logic [4:0] tip);
        if (tip < TIP_MIN) begin
            return TIP_MIN;
        end else if (tip > TIP_MAX) begin
            return TIP_MAX;
        end else begin
            return tip;
        end
    endfunction

endpackage

// File: rtl/phase_accumulator.sv
// Phase accumulator: acc advances by the active tuning word every clock.
// Ports: clk/rst_n; step_load/step_new replace the tuning word at an edge;
// phase (top 12 acc bits), wrap (registered carry), carry/step_zero (to ctrl).
module phase_accumulator #(
    parameter int                   ACC_WIDTH  = 32,
    parameter logic [ACC_WIDTH-1:0] RESET_STEP = ACC_WIDTH'(42950)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step_load,
    input  logic [ACC_WIDTH-1:0] step_new,
    output logic [11:0]          phase,
    output logic                 wrap,
    output logic                 carry,
    output logic                 step_zero
);

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] step_q, step_d;
    logic                 wrap_q, wrap_d;

    // The carry of this edge always uses the old step, even when a new
    // step is loaded at the same edge. A zero step can never carry, which
    // freezes the accumulator and suppresses WRAP without extra logic.
    always_comb begin
        {carry, acc_d} = {1'b0, acc_q} + {1'b0, step_q};
        step_d         = step_load ? step_new : step_q;
        wrap_d         = carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            step_q <= RESET_STEP;
            wrap_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    assign phase     = acc_q[ACC_WIDTH-1 -: 12];
    assign wrap      = wrap_q;
    assign step_zero = (step_q == '0);

endmodule

// File: rtl/triangle_wave_ctrl.sv
// Triangle-wave control: accepts configs over valid/ready, shadows them and
// commits at a phase wrap; clamps tips and offers an automatic tip sweep.
// Ports: CLK/RESET_N, CFG_* handshake, SWEEP_*, PHASE/FORM/TRIANGLE_TIP/WRAP/CFG_ERR.
module triangle_wave_ctrl
    import sig_gen_pkg::*;
#(
    parameter int                   ACC_WIDTH  = 32,
    parameter logic [ACC_WIDTH-1:0] RESET_STEP = ACC_WIDTH'(42950),
    parameter int                   SWEEP_W    = 8
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 CFG_VALID,
    output logic                 CFG_READY,
    input  logic [1:0]           CFG_FORM,
    input  logic [4:0]           CFG_TIP,
    input  logic [ACC_WIDTH-1:0] CFG_STEP,
    input  logic                 SWEEP_EN,
    input  logic [SWEEP_W-1:0]   SWEEP_WRAPS,
    output logic [11:0]          PHASE,
    output logic [1:0]           FORM,
    output logic [4:0]           TRIANGLE_TIP,
    output logic                 WRAP,
    output logic                 CFG_ERR
);

    ctrl_state_t          state_q, state_d;
    logic [1:0]           shd_form_q, shd_form_d;
    logic [4:0]           shd_tip_q, shd_tip_d;
    logic [ACC_WIDTH-1:0] shd_step_q, shd_step_d;
    logic [1:0]           form_q, form_d;
    logic [4:0]           tip_q, tip_d;
    logic                 cfg_err_q, cfg_err_d;
    logic [SWEEP_W-1:0]   sweep_cnt_q, sweep_cnt_d;

    logic                 acc_carry;
    logic                 acc_step_zero;
    logic                 commit;
    logic [4:0]           tip_clamped;
    logic [SWEEP_W-1:0]   sweep_lim;
    logic [SWEEP_W:0]     sweep_cnt_inc;

    phase_accumulator #(
        .ACC_WIDTH  (ACC_WIDTH),
        .RESET_STEP (RESET_STEP)
    ) u_acc (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .step_load (commit),
        .step_new  (shd_step_q),
        .phase     (PHASE),
        .wrap      (WRAP),
        .carry     (acc_carry),
        .step_zero (acc_step_zero)
    );

    always_comb begin
        // A frozen accumulator never carries, so a pending config would
        // stall forever; commit it at the first edge after acceptance.
        commit        = (state_q == PENDING) && (acc_carry || acc_step_zero);
        tip_clamped   = clamp_tip(CFG_TIP);
        sweep_lim     = (SWEEP_WRAPS == '0) ? SWEEP_W'(1) : SWEEP_WRAPS;
        sweep_cnt_inc = {1'b0, sweep_cnt_q} + {{SWEEP_W{1'b0}}, 1'b1};

        state_d     = state_q;
        shd_form_d  = shd_form_q;
        shd_tip_d   = shd_tip_q;
        shd_step_d  = shd_step_q;
        form_d      = form_q;
        tip_d       = tip_q;
        cfg_err_d   = 1'b0;
        sweep_cnt_d = sweep_cnt_q;

        case (state_q)
            IDLE: begin
                if (CFG_VALID) begin
                    shd_form_d = CFG_FORM;
                    shd_tip_d  = tip_clamped;
                    shd_step_d = CFG_STEP;
                    cfg_err_d  = (tip_clamped != CFG_TIP);
                    state_d    = PENDING;
                end
            end
            PENDING: begin
                if (commit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A commit overrides any sweep step and restarts the sweep count
        // so the new tip gets a full sweep interval.
        if (commit) begin
            form_d      = shd_form_q;
            tip_d       = shd_tip_q;
            sweep_cnt_d = '0;
        end else if (!SWEEP_EN) begin
            sweep_cnt_d = '0;
        end else if (acc_carry) begin
            // >= rather than == so lowering SWEEP_WRAPS mid-count still steps.
            if (sweep_cnt_inc >= {1'b0, sweep_lim}) begin
                sweep_cnt_d = '0;
                tip_d       = (tip_q >= TIP_MAX) ? TIP_MIN : tip_q + 5'd1;
            end else begin
                sweep_cnt_d = sweep_cnt_inc[SWEEP_W-1:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            shd_form_q  <= FORM_TRI;
            shd_tip_q   <= TIP_RESET;
            shd_step_q  <= RESET_STEP;
            form_q      <= FORM_TRI;
            tip_q       <= TIP_RESET;
            cfg_err_q   <= 1'b0;
            sweep_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shd_form_q  <= shd_form_d;
            shd_tip_q   <= shd_tip_d;
            shd_step_q  <= shd_step_d;
            form_q      <= form_d;
            tip_q       <= tip_d;
            cfg_err_q   <= cfg_err_d;
            sweep_cnt_q <= sweep_cnt_d;
        end
    end

    assign CFG_READY    = (state_q == IDLE);
    assign FORM         = form_q;
    assign TRIANGLE_TIP = tip_q;
    assign CFG_ERR      = cfg_err_q;

endmodule

// File: tb/tb_triangle_wave_ctrl.sv
module tb_triangle_wave_ctrl;

    localparam logic [31:0] STEP_1  = 32'h0010_0000; // PHASE +1 per cycle
    localparam logic [31:0] STEP_16 = 32'h0100_0000; // PHASE +16 per cycle

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        CFG_VALID;
    logic        CFG_READY;
    logic [1:0]  CFG_FORM;
    logic [4:0]  CFG_TIP;
    logic [31:0] CFG_STEP;
    logic        SWEEP_EN;
    logic [7:0]  SWEEP_WRAPS;
    logic [11:0] PHASE;
    logic [1:0]  FORM;
    logic [4:0]  TRIANGLE_TIP;
    logic        WRAP;
    logic        CFG_ERR;

    int errors = 0;
    int checks = 0;

    triangle_wave_ctrl #(
        .ACC_WIDTH  (32),
        .RESET_STEP (STEP_1),
        .SWEEP_W    (8)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .CFG_VALID    (CFG_VALID),
        .CFG_READY    (CFG_READY),
        .CFG_FORM     (CFG_FORM),
        .CFG_TIP      (CFG_TIP),
        .CFG_STEP     (CFG_STEP),
        .SWEEP_EN     (SWEEP_EN),
        .SWEEP_WRAPS  (SWEEP_WRAPS),
        .PHASE        (PHASE),
        .FORM         (FORM),
        .TRIANGLE_TIP (TRIANGLE_TIP),
        .WRAP         (WRAP),
        .CFG_ERR      (CFG_ERR)
    );

    always #5 CLK = ~CLK;

    // Advance one edge and settle; all driving and sampling happens here.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Advance until WRAP is seen (at least one edge); a timeout is a failure.
    task automatic wait_wrap(input int limit, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            seen = (WRAP === 1'b1);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: no WRAP within %0d cycles", name, limit);
        end
    endtask

    task automatic offer(input logic [1:0] form, input logic [4:0] tip, input logic [31:0] step);
        CFG_VALID = 1'b1;
        CFG_FORM  = form;
        CFG_TIP   = tip;
        CFG_STEP  = step;
        tick();
        CFG_VALID = 1'b0;
    endtask

    task automatic test_reset;
        RESET_N = 1'b0;
        tick(3);
        checks++;
        if ({PHASE, FORM, TRIANGLE_TIP, WRAP, CFG_ERR, CFG_READY} !== {12'd0, 2'd0, 5'd10, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset: phase=%0d form=%0d tip=%0d wrap=%0b err=%0b rdy=%0b want 0 0 10 0 0 1",
                     PHASE, FORM, TRIANGLE_TIP, WRAP, CFG_ERR, CFG_READY);
        end
    endtask

    task automatic test_phase_count;
        RESET_N = 1'b1;
        tick();
        checks++;
        if (PHASE !== 12'd1 || WRAP !== 1'b0) begin
            errors++;
            $display("FAIL count_first: phase=%0d wrap=%0b want 1 0", PHASE, WRAP);
        end
        tick(4094);
        checks++;
        if (PHASE !== 12'd4095 || WRAP !== 1'b0) begin
            errors++;
            $display("FAIL count_4095: phase=%0d wrap=%0b want 4095 0", PHASE, WRAP);
        end
        tick();
        checks++;
        if (PHASE !== 12'd0 || WRAP !== 1'b1 || FORM !== 2'd0 || TRIANGLE_TIP !== 5'd10) begin
            errors++;
            $display("FAIL first_wrap: phase=%0d wrap=%0b form=%0d tip=%0d want 0 1 0 10",
                     PHASE, WRAP, FORM, TRIANGLE_TIP);
        end
        tick();
        checks++;
        if (PHASE !== 12'd1 || WRAP !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pulse_width: phase=%0d wrap=%0b want 1 0", PHASE, WRAP);
        end
    endtask

    task automatic test_accept_commit;
        tick(99);
        checks++;
        if (PHASE !== 12'd100) begin
            errors++;
            $display("FAIL accept_phase: phase=%0d want 100", PHASE);
        end
        offer(2'd2, 5'd5, STEP_1);
        checks++;
        if (CFG_READY !== 1'b0 || CFG_ERR !== 1'b0 || FORM !== 2'd0 || TRIANGLE_TIP !== 5'd10) begin
            errors++;
            $display("FAIL accept_hold: rdy=%0b err=%0b form=%0d tip=%0d want 0 0 0 10",
                     CFG_READY, CFG_ERR, FORM, TRIANGLE_TIP);
        end
        tick(3994);
        checks++;
        if (WRAP !== 1'b0 || FORM !== 2'd0 || TRIANGLE_TIP !== 5'd10 || CFG_READY !== 1'b0) begin
            errors++;
            $display("FAIL pre_commit: wrap=%0b form=%0d tip=%0d rdy=%0b want 0 0 10 0",
                     WRAP, FORM, TRIANGLE_TIP, CFG_READY);
        end
        tick();
        checks++;
        if (WRAP !== 1'b1 || PHASE !== 12'd0 || FORM !== 2'd2 || TRIANGLE_TIP !== 5'd5) begin
            errors++;
            $display("FAIL commit: wrap=%0b phase=%0d form=%0d tip=%0d want 1 0 2 5",
                     WRAP, PHASE, FORM, TRIANGLE_TIP);
        end
        tick();
        checks++;
        if (CFG_READY !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_commit: rdy=%0b want 1", CFG_READY);
        end
    endtask

    task automatic test_clamp;
        offer(2'd1, 5'd0, STEP_1);
        checks++;
        if (CFG_ERR !== 1'b1 || CFG_READY !== 1'b0) begin
            errors++;
            $display("FAIL clamp_low_err: err=%0b rdy=%0b want 1 0", CFG_ERR, CFG_READY);
        end
        tick();
        checks++;
        if (CFG_ERR !== 1'b0) begin
            errors++;
            $display("FAIL clamp_err_pulse: err=%0b want 0", CFG_ERR);
        end
        wait_wrap(5000, "clamp_low_wrap");
        checks++;
        if (TRIANGLE_TIP !== 5'd1 || FORM !== 2'd1) begin
            errors++;
            $display("FAIL clamp_low_tip: tip=%0d form=%0d want 1 1", TRIANGLE_TIP, FORM);
        end
        tick();
        offer(2'd3, 5'd25, STEP_1);
        checks++;
        if (CFG_ERR !== 1'b1) begin
            errors++;
            $display("FAIL clamp_high_err: err=%0b want 1", CFG_ERR);
        end
        wait_wrap(5000, "clamp_high_wrap");
        checks++;
        if (TRIANGLE_TIP !== 5'd19 || FORM !== 2'd3) begin
            errors++;
            $display("FAIL clamp_high_tip: tip=%0d form=%0d want 19 3", TRIANGLE_TIP, FORM);
        end
    endtask

    task automatic test_zero_step;
        bit moved;
        tick();
        offer(2'd0, 5'd7, 32'd0);
        checks++;
        if (CFG_ERR !== 1'b0) begin
            errors++;
            $display("FAIL legal_tip_err: err=%0b want 0", CFG_ERR);
        end
        wait_wrap(5000, "zero_commit_wrap");
        checks++;
        if (TRIANGLE_TIP !== 5'd7 || PHASE !== 12'd0) begin
            errors++;
            $display("FAIL zero_commit: tip=%0d phase=%0d want 7 0", TRIANGLE_TIP, PHASE);
        end
        moved = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (PHASE !== 12'd0 || WRAP !== 1'b0) moved = 1'b1;
        end
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL zero_freeze: phase=%0d wrap=%0b want 0 0", PHASE, WRAP);
        end
        offer(2'd2, 5'd9, STEP_1);
        checks++;
        if (CFG_READY !== 1'b0 || TRIANGLE_TIP !== 5'd7) begin
            errors++;
            $display("FAIL zero_accept: rdy=%0b tip=%0d want 0 7", CFG_READY, TRIANGLE_TIP);
        end
        tick();
        checks++;
        if (TRIANGLE_TIP !== 5'd9 || FORM !== 2'd2 || CFG_READY !== 1'b1 || PHASE !== 12'd0 || WRAP !== 1'b0) begin
            errors++;
            $display("FAIL zero_fast_commit: tip=%0d form=%0d rdy=%0b phase=%0d wrap=%0b want 9 2 1 0 0",
                     TRIANGLE_TIP, FORM, CFG_READY, PHASE, WRAP);
        end
        tick();
        checks++;
        if (PHASE !== 12'd1) begin
            errors++;
            $display("FAIL zero_resume: phase=%0d want 1", PHASE);
        end
    endtask

    task automatic test_sweep;
        logic [4:0] exp_tip [1:8];
        exp_tip = '{5'd18, 5'd19, 5'd19, 5'd1, 5'd1, 5'd4, 5'd4, 5'd5};
        SWEEP_WRAPS = 8'd2;
        offer(2'd0, 5'd18, STEP_16);
        wait_wrap(5000, "sweep_setup_wrap");
        checks++;
        if (TRIANGLE_TIP !== 5'd18) begin
            errors++;
            $display("FAIL sweep_setup: tip=%0d want 18", TRIANGLE_TIP);
        end
        SWEEP_EN = 1'b1;
        for (int w = 1; w <= 8; w++) begin
            wait_wrap(300, "sweep_wrap");
            checks++;
            if (TRIANGLE_TIP !== exp_tip[w]) begin
                errors++;
                $display("FAIL sweep_tip[%0d]: tip=%0d want %0d", w, TRIANGLE_TIP, exp_tip[w]);
            end
            if (w == 6) begin
                checks++;
                if (FORM !== 2'd1) begin
                    errors++;
                    $display("FAIL sweep_commit_form: form=%0d want 1", FORM);
                end
            end
            // Config lands on wrap 6, which is also a sweep-step wrap.
            if (w == 5) offer(2'd1, 5'd4, STEP_16);
        end
    endtask

    task automatic test_reset_pending;
        SWEEP_EN = 1'b0;
        tick();
        offer(2'd3, 5'd3, STEP_1);
        checks++;
        if (CFG_READY !== 1'b0) begin
            errors++;
            $display("FAIL pend_before_reset: rdy=%0b want 0", CFG_READY);
        end
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({PHASE, FORM, TRIANGLE_TIP, WRAP, CFG_ERR, CFG_READY} !== {12'd0, 2'd0, 5'd10, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: phase=%0d form=%0d tip=%0d wrap=%0b err=%0b rdy=%0b want 0 0 10 0 0 1",
                     PHASE, FORM, TRIANGLE_TIP, WRAP, CFG_ERR, CFG_READY);
        end
        tick();
        RESET_N = 1'b1;
        tick();
        checks++;
        if (PHASE !== 12'd1) begin
            errors++;
            $display("FAIL reset_step: phase=%0d want 1", PHASE);
        end
        tick(4095);
        checks++;
        if (WRAP !== 1'b1 || PHASE !== 12'd0 || FORM !== 2'd0 || TRIANGLE_TIP !== 5'd10) begin
            errors++;
            $display("FAIL shadow_discarded: wrap=%0b phase=%0d form=%0d tip=%0d want 1 0 0 10",
                     WRAP, PHASE, FORM, TRIANGLE_TIP);
        end
    endtask

    initial begin
        RESET_N     = 1'b0;
        CFG_VALID   = 1'b0;
        CFG_FORM    = 2'd0;
        CFG_TIP     = 5'd0;
        CFG_STEP    = 32'd0;
        SWEEP_EN    = 1'b0;
        SWEEP_WRAPS = 8'd0;
        test_reset();
        test_phase_count();
        test_accept_commit();
        test_clamp();
        test_zero_step();
        test_sweep();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
